fpa_array_loader: RTL and testbench
===================================

// Module: fpa_array_loader
// PURPOSE
//  Upstream feeder for the FP32 array adder. Collects a serial valid/ready stream of FP32
//  words into an (N+1)-entry register array and presents it to the adder with an enable.
//  Holds the array stable until the adder's data-valid pulse, then clears and refills.
//  Input words are screened for NaN; a short frame is closed early with iLAST, zero padded.
// PARAMETERS
//  DATA_WIDTH  32  word width; only 32 (IEEE-754 single) is supported
//  N           16  array upper index; array holds N+1 words, indices 0..N
// PORTS
//  iCLK             in   1             clock; all state changes on rising edge
//  iRESET           in   1             asynchronous, active-high reset
//  iVALID           in   1             upstream word valid
//  oREADY           out  1             loader accepts a word this cycle
//  iDATA            in   DATA_WIDTH    FP32 input word
//  iLAST            in   1             qualifies iDATA as final word of the frame
//  oFPA_NUMBERS     out  DATA_WIDTH x [N:0]  array to the adder (unpacked, index 0 = first word)
//  oEN              out  1             array complete and stable; enable to the adder
//  iFPA_DATA_VALID  in   1             adder result valid; releases the array
//  oCOUNT           out  $clog2(N+2)   number of words accepted into the current frame
//  oNAN_SEEN        out  1             sticky: a NaN was accepted into the current frame
// BEHAVIOUR
//  Reset (async, iRESET=1): state FILL, all oFPA_NUMBERS=32'h0, oEN=0, oREADY=0 while reset
//   is held, oCOUNT=0, oNAN_SEEN=0. oREADY rises the first cycle after reset is released.
//  Handshake: a word is accepted on an edge where iVALID && oREADY. oREADY is a registered
//   state decode: 1 only in FILL. iDATA/iLAST are ignored when not accepted.
//  FSM FILL:
//   - Each accept writes iDATA to entry oCOUNT and increments oCOUNT.
//   - Accept with oCOUNT==N, or accept with iLAST=1, moves to HOLD.
//   - On an iLAST accept at index k<N, entries k+1..N stay +0.0 (32'h0) from the last clear.
//  FSM HOLD:
//   - oEN=1 from the cycle after the final accept (1-cycle latency). oREADY=0.
//   - Array and oCOUNT are frozen.
//   - iFPA_DATA_VALID=1 moves to CLEAR.
//  FSM CLEAR (1 cycle):
//   - oEN=0; all entries <= 32'h0, oCOUNT <= 0, oNAN_SEEN <= 0. Next state is FILL.
//   - Release-to-next-accept is therefore 2 cycles.
//  iFPA_DATA_VALID in FILL or CLEAR: ignored, no state change.
//  iLAST with oCOUNT==N: same as a normal final word, no padding.
//  iLAST on the first word: frame of one word; entries 1..N are zero.
//  NaN: exp==8'hFF && frac!=0. oNAN_SEEN is set the cycle after the accept and cleared only
//   in CLEAR or on reset. The word is stored unchanged. Inf is not flagged.
//  Reset asserted mid-frame or in HOLD: frame discarded immediately; no partial oEN pulse.
//  oCOUNT saturates at N+1; it cannot wrap because oREADY=0 outside FILL.
// CONFIGURATION
//  FPA_DENORM_FLUSH_EN defined:
//   - Subnormal inputs (exp==0, frac!=0) are stored as signed zero {sign,31'h0}.
//   - No added latency.
//  FPA_DENORM_FLUSH_EN undefined: subnormals are stored bit-exact.
//  The NaN screen is unaffected by the macro.
// STRUCTURE
//  fpa_pkg (shared with the adder):
//   - typedef logic [31:0] fp32_t
//   - localparams FP32_ZERO, FP32_EXP_MSB/LSB, FP32_FRAC_W
//   - typedef enum {FILL,HOLD,CLEAR} ld_state_e
//   - functions is_nan(fp32_t), is_denorm(fp32_t)
//  Sub-module fp32_classify:
//   - Combinational; fp32_t in.
//   - Outputs: is_nan, is_inf, is_denorm, and the flushed word.
//   - One instance on iDATA.
//  Loader body is a single FSM plus an array register file; no other sub-modules.
// TESTING
//  1 Full frame: 17 back-to-back words 1.0..17.0 (32'h3F800000..), iVALID=1 ->
//    oREADY drops after the 17th accept; oEN=1 next cycle; oFPA_NUMBERS[16]=32'h41880000;
//    oCOUNT=17.
//  2 Short frame: 3 words 2.0, 3.0, 4.0 with iLAST on the 3rd -> oEN=1; entries 3..16=0;
//    oCOUNT=3.
//  3 Release: in HOLD pulse iFPA_DATA_VALID 1 cycle -> oEN=0 next cycle; array all zero;
//    oREADY=1 two cycles after the pulse; the next word lands in entry 0.
//  4 Backpressure and ignore: iVALID toggling 1/0 during FILL, extra iVALID during HOLD,
//    iFPA_DATA_VALID during FILL -> only the qualified words are stored; no state change
//    from the stray pulses.
//  5 Screening: accept 32'h7FC00000 then 32'h00000001 -> oNAN_SEEN=1.
//    With FPA_DENORM_FLUSH_EN, entry 1=32'h0; without it, entry 1=32'h00000001.
//  6 Async reset: assert iRESET mid-edge while oCOUNT=9 -> outputs zero without a clock;
//    oREADY=0 until release, then 1 the next cycle.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared FP32 types, field positions and classification helpers for the array adder and its loader.
package fpa_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO    = 32'h0000_0000;
  localparam int    FP32_EXP_MSB = 30;
  localparam int    FP32_EXP_LSB = 23;
  localparam int    FP32_FRAC_W  = 23;

  typedef enum logic [1:0] {FILL, HOLD, CLEAR} ld_state_e;

  function automatic logic is_nan(input fp32_t w);
    return (w[FP32_EXP_MSB:FP32_EXP_LSB] == 8'hFF) && (w[FP32_FRAC_W-1:0] != '0);
  endfunction

  function automatic logic is_denorm(input fp32_t w);
    return (w[FP32_EXP_MSB:FP32_EXP_LSB] == 8'h00) && (w[FP32_FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: NaN / Inf / subnormal flags and the sign-preserving flushed word.
module fp32_classify
  import fpa_pkg::*;
(
  input  fp32_t word,
  output logic  nan,
  output logic  inf,
  output logic  denorm,
  output fp32_t flushed
);

  assign nan     = is_nan(word);
  assign denorm  = is_denorm(word);
  assign inf     = (word[FP32_EXP_MSB:FP32_EXP_LSB] == 8'hFF) && (word[FP32_FRAC_W-1:0] == '0);
  assign flushed = denorm ? {word[31], 31'h0} : word;

endmodule

// File: rtl/fpa_array_loader.sv
// Serial-to-array feeder for the FP32 array adder: fill, hold until the adder consumes, clear.
// Optional build macro FPA_DENORM_FLUSH_EN stores subnormal inputs as signed zero.
module fpa_array_loader
  import fpa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iVALID,
  output logic                      oREADY,
  input  logic [DATA_WIDTH-1:0]     iDATA,
  input  logic                      iLAST,
  output logic [DATA_WIDTH-1:0]     oFPA_NUMBERS [N:0],
  output logic                      oEN,
  input  logic                      iFPA_DATA_VALID,
  output logic [$clog2(N+2)-1:0]    oCOUNT,
  output logic                      oNAN_SEEN
);

  localparam int CNT_W = $clog2(N+2);

`ifdef FPA_DENORM_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  ld_state_e state, state_next;
  logic      accept;
  logic      word_nan;
  logic      word_denorm;
  logic      inf_unused;
  fp32_t     word_flushed;
  fp32_t     store_word;

  fp32_classify u_classify (
    .word    (iDATA),
    .nan     (word_nan),
    .inf     (inf_unused),
    .denorm  (word_denorm),
    .flushed (word_flushed)
  );

  // oREADY is a registered decode of FILL, so it alone qualifies the handshake.
  assign accept     = iVALID && oREADY;
  assign store_word = (FLUSH_EN && word_denorm) ? word_flushed : iDATA;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state  <= FILL;
      oREADY <= 1'b0;
      oEN    <= 1'b0;
    end else begin
      state  <= state_next;
      oREADY <= (state_next == FILL);
      oEN    <= (state_next == HOLD);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (accept && (iLAST || oCOUNT == CNT_W'(N))) state_next = HOLD;
      HOLD:    if (iFPA_DATA_VALID) state_next = CLEAR;
      CLEAR:   state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Array register file; unused tail entries keep the zero written by the last clear.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i <= N; i++) oFPA_NUMBERS[i] <= FP32_ZERO;
      oCOUNT    <= '0;
      oNAN_SEEN <= 1'b0;
    end else if (state == CLEAR) begin
      for (int i = 0; i <= N; i++) oFPA_NUMBERS[i] <= FP32_ZERO;
      oCOUNT    <= '0;
      oNAN_SEEN <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i <= N; i++)
        if (oCOUNT == CNT_W'(i)) oFPA_NUMBERS[i] <= store_word;
      if (oCOUNT != CNT_W'(N+1)) oCOUNT <= oCOUNT + CNT_W'(1);
      if (word_nan) oNAN_SEEN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpa_array_loader.sv
// Directed bench for fpa_array_loader: full frame, table-driven short/stray/screen/release vectors, async reset.
module tb_fpa_array_loader;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iVALID;
  logic        oREADY;
  logic [31:0] iDATA;
  logic        iLAST;
  logic [31:0] oFPA_NUMBERS [16:0];
  logic        oEN;
  logic        iFPA_DATA_VALID;
  logic [4:0]  oCOUNT;
  logic        oNAN_SEEN;

  int tests = 0;
  int fails = 0;

`ifdef FPA_DENORM_FLUSH_EN
  localparam logic [31:0] EXP_SUB = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_SUB = 32'h0000_0001;
`endif

  fpa_array_loader #(.DATA_WIDTH(32), .N(16)) dut (
    .iCLK            (iCLK),
    .iRESET          (iRESET),
    .iVALID          (iVALID),
    .oREADY          (oREADY),
    .iDATA           (iDATA),
    .iLAST           (iLAST),
    .oFPA_NUMBERS    (oFPA_NUMBERS),
    .oEN             (oEN),
    .iFPA_DATA_VALID (iFPA_DATA_VALID),
    .oCOUNT          (oCOUNT),
    .oNAN_SEEN       (oNAN_SEEN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        f;
    logic        r;
    logic        e;
    logic [4:0]  c;
    logic        n;
    int          ac;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] ones_to_17 [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] or_from(input int lo);
    logic [31:0] acc = '0;
    for (int i = lo; i <= 16; i++) acc |= oFPA_NUMBERS[i];
    return acc;
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    ones_to_17 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                   32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000,
                   32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000,
                   32'h41800000, 32'h41880000};
    //                v     d             l     f     r     e     c      n     ac
    vecs[0]  = '{1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 0};
    vecs[1]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'h40400000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 0};
    vecs[3]  = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 0};
    vecs[4]  = '{1'b1, 32'h40800000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 0};
    vecs[5]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 0};
    vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1};
    vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 0};
    vecs[8]  = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3};
    vecs[9]  = '{1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 0};
    vecs[10] = '{1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 2};
    vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 0};
    vecs[12] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3};
    vecs[13] = '{1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 4};
    vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 0};
    vecs[15] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3};

    iRESET = 1'b1; iVALID = 1'b0; iDATA = '0; iLAST = 1'b0; iFPA_DATA_VALID = 1'b0;
    step(); step();
    chk("rst_ready", 32'(oREADY), 32'd0);
    chk("rst_en",    32'(oEN), 32'd0);
    chk("rst_count", 32'(oCOUNT), 32'd0);
    chk("rst_nan",   32'(oNAN_SEEN), 32'd0);
    chk("rst_array", or_from(0), 32'd0);
    iRESET = 1'b0;
    #1;
    chk("rel_ready_low", 32'(oREADY), 32'd0);
    step();
    chk("rel_ready_high", 32'(oREADY), 32'd1);

    // Full 17-word frame, back to back
    for (int i = 0; i < 17; i++) begin
      iVALID = 1'b1; iDATA = ones_to_17[i]; iLAST = 1'b0;
      step();
      chk($sformatf("full_count_%0d", i), 32'(oCOUNT), 32'(i + 1));
      chk($sformatf("full_ready_%0d", i), 32'(oREADY), (i == 16) ? 32'd0 : 32'd1);
      chk($sformatf("full_en_%0d", i),    32'(oEN),    (i == 16) ? 32'd1 : 32'd0);
    end
    iVALID = 1'b0;
    for (int i = 0; i < 17; i++) chk($sformatf("full_entry_%0d", i), oFPA_NUMBERS[i], ones_to_17[i]);
    chk("full_entry16_17p0", oFPA_NUMBERS[16], 32'h41880000);

    // Release with a one-cycle adder pulse
    iFPA_DATA_VALID = 1'b1;
    step();
    iFPA_DATA_VALID = 1'b0;
    chk("rel_en_low",  32'(oEN), 32'd0);
    chk("rel_ready_0", 32'(oREADY), 32'd0);
    step();
    chk("rel_ready_1", 32'(oREADY), 32'd1);
    chk("rel_count",   32'(oCOUNT), 32'd0);
    chk("rel_array",   or_from(0), 32'd0);

    // Table: backpressure, stray pulses, short frame, release, screening, one-word frame
    for (int k = 0; k < 16; k++) begin
      iVALID = vecs[k].v; iDATA = vecs[k].d; iLAST = vecs[k].l; iFPA_DATA_VALID = vecs[k].f;
      step();
      chk($sformatf("vec%0d_ready", k), 32'(oREADY),    32'(vecs[k].r));
      chk($sformatf("vec%0d_en", k),    32'(oEN),       32'(vecs[k].e));
      chk($sformatf("vec%0d_count", k), 32'(oCOUNT),    32'(vecs[k].c));
      chk($sformatf("vec%0d_nan", k),   32'(oNAN_SEEN), 32'(vecs[k].n));
      case (vecs[k].ac)
        1: begin
          chk("short_e0", oFPA_NUMBERS[0], 32'h40000000);
          chk("short_e1", oFPA_NUMBERS[1], 32'h40400000);
          chk("short_e2", oFPA_NUMBERS[2], 32'h40800000);
          chk("short_pad", or_from(3), 32'd0);
        end
        2: begin
          chk("screen_e0", oFPA_NUMBERS[0], 32'h7FC00000);
          chk("screen_e1", oFPA_NUMBERS[1], EXP_SUB);
        end
        3: chk($sformatf("vec%0d_cleared", k), or_from(0), 32'd0);
        4: begin
          chk("one_e0", oFPA_NUMBERS[0], 32'h3F800000);
          chk("one_pad", or_from(1), 32'd0);
        end
        default: ;
      endcase
    end
    iVALID = 1'b0; iLAST = 1'b0; iFPA_DATA_VALID = 1'b0;

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 9; i++) begin
      iVALID = 1'b1; iDATA = ones_to_17[i];
      step();
    end
    iVALID = 1'b0;
    chk("pre_rst_count", 32'(oCOUNT), 32'd9);
    #2;
    iRESET = 1'b1;
    #1;
    chk("arst_count", 32'(oCOUNT), 32'd0);
    chk("arst_ready", 32'(oREADY), 32'd0);
    chk("arst_en",    32'(oEN), 32'd0);
    chk("arst_array", or_from(0), 32'd0);
    step();
    chk("arst_hold_ready", 32'(oREADY), 32'd0);
    iRESET = 1'b0;
    #1;
    chk("arst_rel_ready_low", 32'(oREADY), 32'd0);
    step();
    chk("arst_rel_ready_high", 32'(oREADY), 32'd1);
    chk("arst_rel_en", 32'(oEN), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
